// File: rtl/cassette_decoder_pkg.sv
// Shared cassette constants and types; the tone generator imports the same package.
package cassette_decoder_pkg;

    // Default timing at 50 MHz: 800 Hz .. 5000 Hz window, 1800 Hz split between 1 and 0.
    localparam int unsigned CAS_MIN_P  = 10000;
    localparam int unsigned CAS_THR_P  = 27778;
    localparam int unsigned CAS_MAX_P  = 62500;
    localparam logic [7:0]  CAS_SYNC_B = 8'h3C;

    // Period counter width; must hold MAX_P+1.
    localparam int unsigned CAS_CNT_W = 17;

    typedef enum logic [0:0] {
        StHunt,
        StFrame
    } frame_state_e;

endpackage

// File: rtl/cas_bit_det.sv
// Cassette bit detector: input synchroniser, rising-edge period counter and 1/0 classifier.
module cas_bit_det
    import cassette_decoder_pkg::*;
#(
    parameter int unsigned MIN_P = CAS_MIN_P,
    parameter int unsigned THR_P = CAS_THR_P,
    parameter int unsigned MAX_P = CAS_MAX_P
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cas_in,
    input  logic enable,
    output logic bit_stb,
    output logic bit_val,
    output logic carrier
);

    localparam logic [CAS_CNT_W-1:0] CntMin = CAS_CNT_W'(MIN_P);
    localparam logic [CAS_CNT_W-1:0] CntThr = CAS_CNT_W'(THR_P);
    localparam logic [CAS_CNT_W-1:0] CntMax = CAS_CNT_W'(MAX_P);
    localparam logic [CAS_CNT_W-1:0] CntSat = CAS_CNT_W'(MAX_P + 1);

    logic [2:0]           sync_q;
    logic                 rise;
    logic                 in_range;
    logic [CAS_CNT_W-1:0] cnt_q, cnt_d;
    logic                 bit_stb_q, bit_val_q, carrier_q;

    // [0],[1] form the two-flop synchroniser; [2] is the edge-detect history.
    assign rise     = sync_q[1] & ~sync_q[2];
    assign in_range = rise && (cnt_q >= CntMin) && (cnt_q <= CntMax);

    // Synchroniser and edge history shift register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], cas_in};
        end
    end

    // Period counter: restart on a non-glitch edge, otherwise count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (rise && (cnt_q >= CntMin)) begin
            cnt_d = CAS_CNT_W'(1);
        end else if (cnt_q != CntSat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter, classification strobe and carrier state; an edge after saturation only restarts.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= CntSat;
            bit_stb_q <= 1'b0;
            bit_val_q <= 1'b0;
            carrier_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_stb_q <= in_range & enable;
            if (in_range && enable) begin
                bit_val_q <= (cnt_q < CntThr);
            end
            if (in_range) begin
                carrier_q <= 1'b1;
            end else if (cnt_d == CntSat) begin
                carrier_q <= 1'b0;
            end
        end
    end

    assign bit_stb = bit_stb_q;
    assign bit_val = bit_val_q;
    assign carrier = carrier_q;

endmodule

// File: rtl/cassette_decoder.sv
// Cassette decoder top: bit detector plus HUNT/FRAME byte framing on a sync byte.
module cassette_decoder
    import cassette_decoder_pkg::*;
#(
    parameter int unsigned MIN_P  = CAS_MIN_P,
    parameter int unsigned THR_P  = CAS_THR_P,
    parameter int unsigned MAX_P  = CAS_MAX_P,
    parameter logic [7:0]  SYNC_B = CAS_SYNC_B
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cas_in,
    input  logic       enable,
    output logic       bit_stb,
    output logic       bit_val,
    output logic       byte_stb,
    output logic [7:0] byte_out,
    output logic       synced,
    output logic       carrier
);

    logic         det_stb, det_val, det_carrier;
    frame_state_e state_q, state_d;
    logic [7:0]   shift_q, shift_d, shift_next;
    logic [2:0]   cnt_q, cnt_d;
    logic [7:0]   byte_q, byte_d;
    logic         byte_stb_q, byte_stb_d;

    cas_bit_det #(
        .MIN_P (MIN_P),
        .THR_P (THR_P),
        .MAX_P (MAX_P)
    ) u_bit_det (
        .clk     (clk),
        .reset_n (reset_n),
        .cas_in  (cas_in),
        .enable  (enable),
        .bit_stb (det_stb),
        .bit_val (det_val),
        .carrier (det_carrier)
    );

    // Bits arrive LSB first: the newest bit enters at the top.
    assign shift_next = {det_val, shift_q[7:1]};

    // Framing next-state; carrier loss or disable wins over any bit arriving this cycle.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        byte_stb_d = 1'b0;
        if (!det_carrier || !enable) begin
            state_d = StHunt;
            shift_d = '0;
            cnt_d   = '0;
        end else if (det_stb) begin
            shift_d = shift_next;
            case (state_q)
                StHunt: begin
                    if (shift_next == SYNC_B) begin
                        state_d = StFrame;
                        cnt_d   = '0;
                    end
                end
                StFrame: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        byte_d     = shift_next;
                        byte_stb_d = 1'b1;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // Framing state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StHunt;
            shift_q    <= '0;
            cnt_q      <= '0;
            byte_q     <= '0;
            byte_stb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            byte_stb_q <= byte_stb_d;
        end
    end

    // Mask the strobe registered in the cycle enable falls.
    assign bit_stb  = det_stb & enable;
    assign bit_val  = det_val;
    assign byte_stb = byte_stb_q;
    assign byte_out = byte_q;
    assign synced   = (state_q == StFrame);
    assign carrier  = det_carrier;

endmodule

// File: tb/tb_cassette_decoder.sv
// Self-checking bench for cassette_decoder with timing constants scaled down by 250.
module tb_cassette_decoder;

    localparam int unsigned MIN_P  = 40;
    localparam int unsigned THR_P  = 111;
    localparam int unsigned MAX_P  = 250;
    localparam logic [7:0]  SYNC_B = 8'h3C;
    localparam int HI   = 12;   // high time of each generated cycle
    localparam int P1   = 83;   // 2400 Hz scaled
    localparam int P0   = 167;  // 1200 Hz scaled
    localparam int IDLE = 300;  // longer than MAX_P+1 plus pipeline

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cas_in = 1'b0;
    logic       enable = 1'b1;
    logic       bit_stb, bit_val, byte_stb, synced, carrier;
    logic [7:0] byte_out;

    int   checks = 0;
    int   errors = 0;
    bit   exp_bits[$];
    logic [7:0] exp_bytes[$];
    logic prev_bit_stb = 1'b0;
    logic prev_byte_stb = 1'b0;
    logic snap_synced, snap_carrier;
    logic s;

    typedef struct {
        int p;
        bit glitch;
        bit stb;
        bit val;
        bit car;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    cassette_decoder #(
        .MIN_P  (MIN_P),
        .THR_P  (THR_P),
        .MAX_P  (MAX_P),
        .SYNC_B (SYNC_B)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cas_in   (cas_in),
        .enable   (enable),
        .bit_stb  (bit_stb),
        .bit_val  (bit_val),
        .byte_stb (byte_stb),
        .byte_out (byte_out),
        .synced   (synced),
        .carrier  (carrier)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (bit_stb) begin
            if (exp_bits.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bit_stb_unexpected: got strobe bit_val=%0b expected none", bit_val);
            end else begin
                check("bit_val", bit_val, exp_bits.pop_front());
            end
            check("bit_stb_width", prev_bit_stb, 1'b0);
        end
        if (byte_stb) begin
            if (exp_bytes.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL byte_stb_unexpected: got strobe byte_out=%0h expected none",
                         byte_out);
            end else begin
                check("byte_out", byte_out, exp_bytes.pop_front());
            end
            check("byte_stb_width", prev_byte_stb, 1'b0);
        end
        prev_bit_stb  = bit_stb;
        prev_byte_stb = byte_stb;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cas_in = 1'b0;
        tick(IDLE);
    endtask

    // Assumes cas_in rose at the call; ends with the next rising edge p clocks later.
    task automatic period(int p, bit glitch, bit push, bit val);
        if (push) exp_bits.push_back(val);
        tick(HI);
        snap_synced  = synced;
        snap_carrier = carrier;
        cas_in = 1'b0;
        if (glitch) begin
            tick(12);
            cas_in = 1'b1;
            tick(4);
            cas_in = 1'b0;
            tick(p - HI - 16);
        end else begin
            tick(p - HI);
        end
        cas_in = 1'b1;
    endtask

    // s0 is synced as seen early in the first bit, i.e. after the previous byte.
    task automatic send_byte(logic [7:0] b, bit push, output logic s0);
        s0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            period(b[i] ? P1 : P0, 1'b0, push, b[i]);
            if (i == 0) s0 = snap_synced;
        end
    endtask

    task automatic check_outputs_reset(string tag);
        check({tag, "_bit_stb"}, bit_stb, 1'b0);
        check({tag, "_bit_val"}, bit_val, 1'b0);
        check({tag, "_byte_stb"}, byte_stb, 1'b0);
        check({tag, "_byte_out"}, byte_out, 8'h00);
        check({tag, "_synced"}, synced, 1'b0);
        check({tag, "_carrier"}, carrier, 1'b0);
    endtask

    initial begin
        // Boundary periods (scaled): threshold, glitch floor, carrier ceiling, glitch pulse.
        vecs = '{
            '{110, 1'b0, 1'b1, 1'b1, 1'b1},
            '{111, 1'b0, 1'b1, 1'b0, 1'b1},
            '{39,  1'b0, 1'b0, 1'b0, 1'b0},
            '{40,  1'b0, 1'b1, 1'b1, 1'b1},
            '{250, 1'b0, 1'b1, 1'b0, 1'b1},
            '{251, 1'b0, 1'b0, 1'b0, 1'b0},
            '{83,  1'b1, 1'b1, 1'b1, 1'b1}
        };

        reset_n = 1'b0;
        tick(3);
        check_outputs_reset("reset");
        reset_n = 1'b1;
        tick(2);

        foreach (vecs[i]) begin
            idle();
            cas_in = 1'b1;
            period(vecs[i].p, vecs[i].glitch, vecs[i].stb, vecs[i].val);
            tick(8);
            check($sformatf("row%0d_carrier", i), carrier, vecs[i].car);
            cas_in = 1'b0;
            tick(4);
            check($sformatf("row%0d_bits_pending", i), exp_bits.size(), 0);
        end

        // Clean tones with one glitched cycle, then low tones.
        idle();
        cas_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            period(P1, 1'b0, 1'b1, 1'b1);
            if (k == 0) check("carrier_before_first_bit", snap_carrier, 1'b0);
            if (k == 1) check("carrier_after_first_bit", snap_carrier, 1'b1);
        end
        period(P1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) period(P0, 1'b0, 1'b1, 1'b0);
        tick(8);
        check("tones_bits_pending", exp_bits.size(), 0);
        idle();
        check("tones_carrier_lost", carrier, 1'b0);

        // Leader, sync, one data byte.
        cas_in = 1'b1;
        for (int k = 0; k < 4; k++) send_byte(8'h55, 1'b1, s);
        send_byte(8'h3C, 1'b1, s);
        check("synced_before_sync", s, 1'b0);
        exp_bytes.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, s);
        check("synced_after_sync", s, 1'b1);
        tick(8);
        check("byte_out_held_a5", byte_out, 8'hA5);
        check("sync_bytes_pending", exp_bytes.size(), 0);
        check("sync_bits_pending", exp_bits.size(), 0);

        // Dropout after three bits of a framed byte.
        idle();
        cas_in = 1'b1;
        send_byte(8'h3C, 1'b1, s);
        for (int k = 0; k < 3; k++) period(P1, 1'b0, 1'b1, 1'b1);
        check("dropout_synced_before", snap_synced, 1'b1);
        tick(HI);
        cas_in = 1'b0;
        tick(280);
        check("dropout_carrier", carrier, 1'b0);
        check("dropout_synced", synced, 1'b0);
        check("dropout_byte_out", byte_out, 8'hA5);
        check("dropout_bits_pending", exp_bits.size(), 0);
        cas_in = 1'b1;
        send_byte(8'h42, 1'b1, s);
        tick(8);
        check("rehunt_no_sync", synced, 1'b0);

        // Disabled decoder: no strobes, never frames.
        idle();
        enable = 1'b0;
        cas_in = 1'b1;
        send_byte(8'h3C, 1'b0, s);
        send_byte(8'hA5, 1'b0, s);
        tick(8);
        check("disabled_synced", synced, 1'b0);
        enable = 1'b1;
        idle();

        // Reset in the middle of a framed byte.
        cas_in = 1'b1;
        send_byte(8'h3C, 1'b1, s);
        for (int k = 0; k < 3; k++) period(P1, 1'b0, 1'b1, 1'b1);
        tick(10);
        check("midbyte_synced", synced, 1'b1);
        cas_in  = 1'b0;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check_outputs_reset("midreset");
        tick(2);
        cas_in = 1'b1;
        send_byte(8'h3C, 1'b1, s);
        exp_bytes.push_back(8'h42);
        send_byte(8'h42, 1'b1, s);
        tick(8);
        check("after_reset_byte_out", byte_out, 8'h42);
        check("after_reset_bytes_pending", exp_bytes.size(), 0);
        check("after_reset_bits_pending", exp_bits.size(), 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
